// File: rtl/sensor_pkg.sv
// sensor_pkg: shared sensor register map, FSM states and swing thresholds
package sensor_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_TICK, REQ_HI, REQ_LO, PUBLISH} state_t;
   localparam logic [7:0] REG_ACCEL_X_H = 8'h3B;
   localparam logic [7:0] REG_ACCEL_X_L = 8'h3C;
   localparam logic [7:0] REG_ACCEL_Y_H = 8'h3D;
   localparam logic [7:0] REG_ACCEL_Y_L = 8'h3E;
   localparam logic [7:0] REG_ACCEL_Z_H = 8'h3F;
   localparam logic [7:0] REG_ACCEL_Z_L = 8'h40;
   localparam logic [6:0] DEV_ADDR = 7'h68;
   localparam logic signed [15:0] UPBOUND = 16'sd8192;
   localparam logic signed [15:0] DOWNBOUND = -16'sd8192;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/sensor_read_sequencer_if.sv
// sensor_read_sequencer_if: byte-read handshake between sequencer (master) and I2C engine (slave)
interface sensor_read_sequencer_if;
   logic       rd_req;
   logic [7:0] rd_reg;
   logic       rd_done;
   logic       rd_err;
   logic [7:0] rd_data;
   modport master (output rd_req, rd_reg, input rd_done, rd_err, rd_data);
   modport slave (input rd_req, rd_reg, output rd_done, rd_err, rd_data);
endinterface

// File: rtl/poll_tick_gen.sv
// poll_tick_gen: free-running poll counter, held at zero while disabled, pulsing tick on its last count
module poll_tick_gen #(
   parameter int unsigned PERIOD = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);
   localparam int W = $clog2(PERIOD);
   logic [W-1:0] cnt_q;
   assign tick_o = en_i && (cnt_q == W'(PERIOD - 1));
   always_ff @(posedge clk) begin
      if (rst || !en_i || tick_o) cnt_q <= '0;
      else cnt_q <= cnt_q + W'(1);
   end
endmodule

// File: rtl/sensor_read_sequencer.sv
// sensor_read_sequencer: polls a signed 16-bit sample as two byte reads and publishes it with a strobe
module sensor_read_sequencer
   import sensor_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 500000,
   parameter int unsigned TIMEOUT     = 4096,
   parameter logic [7:0]  REG_HI      = REG_ACCEL_X_H,
   parameter logic [7:0]  REG_LO      = REG_ACCEL_X_L
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable_i,
   sensor_read_sequencer_if.master   rd_bus,
   output logic signed [15:0]        raw_data_o,
   output logic                      raw_valid_o,
   output logic                      busy_o,
   output logic [7:0]                err_count_o,
   output logic                      overrun_o
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t       state_q;
   logic         rd_req_q, raw_valid_q, busy_q, ovr_q, tick;
   logic [7:0]   rd_reg_q, hi_q, err_q;
   logic [15:0]  raw_q;
   logic [TW-1:0] to_q;
   logic         fail;
   poll_tick_gen #(.PERIOD(POLL_PERIOD)) u_tick (
      .clk(clk), .rst(rst), .en_i(enable_i), .tick_o(tick)
   );
   // an answer on the last allowed cycle still counts; a simultaneous error wins
   assign fail = rd_bus.rd_err || (!rd_bus.rd_done && to_q == TW'(TIMEOUT - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_req_q    <= 1'b0;
         rd_reg_q    <= '0;
         hi_q        <= '0;
         raw_q       <= '0;
         raw_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= '0;
         ovr_q       <= 1'b0;
         to_q        <= '0;
      end else begin
         raw_valid_q <= 1'b0;
         if (tick && busy_q) ovr_q <= 1'b1;
         case (state_q)
            IDLE: if (enable_i) state_q <= WAIT_TICK;
            WAIT_TICK: begin
               if (!enable_i) state_q <= IDLE;
               else if (tick) begin
                  state_q  <= REQ_HI;
                  rd_req_q <= 1'b1;
                  rd_reg_q <= REG_HI;
                  busy_q   <= 1'b1;
                  to_q     <= '0;
               end
            end
            REQ_HI, REQ_LO: begin
               if (fail) begin
                  state_q  <= enable_i ? WAIT_TICK : IDLE;
                  rd_req_q <= 1'b0;
                  busy_q   <= 1'b0;
                  err_q    <= sat_inc(err_q);
               end else if (rd_bus.rd_done) begin
                  to_q <= '0;
                  if (state_q == REQ_HI) begin
                     state_q  <= REQ_LO;
                     hi_q     <= rd_bus.rd_data;
                     rd_reg_q <= REG_LO;
                  end else begin
                     state_q     <= PUBLISH;
                     raw_q       <= {hi_q, rd_bus.rd_data};
                     raw_valid_q <= 1'b1;
                     rd_req_q    <= 1'b0;
                  end
               end else to_q <= to_q + TW'(1);
            end
            PUBLISH: begin
               state_q <= enable_i ? WAIT_TICK : IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign rd_bus.rd_req = rd_req_q;
   assign rd_bus.rd_reg = rd_reg_q;
   assign raw_data_o    = raw_q;
   assign raw_valid_o   = raw_valid_q;
   assign busy_o        = busy_q;
   assign err_count_o   = err_q;
   assign overrun_o     = ovr_q;
endmodule
